bounce_scan_ctrl: RTL and testbench
===================================

Name: bounce_scan_ctrl

Overview:
Sequencer for the 8-bit-class bounce shift register (one-hot position bouncing LSB<->MSB). The block accepts a start command with a step-rate divider and a sweep count, and issues paced single-cycle shift enables. It counts arrivals of the position at the LSB and stops the shifter exactly on the LSB when the programmed count is reached. It sits between the register/CPU-side control and the shifter's ena input.

Parameters:
DIV_W, 16, width of step-rate divider cfg_div
CNT_W, 8, width of sweep target cfg_sweeps and sweep_count

Ports:
clk  in  1  clock; all state on rising edge
rstna  in  1  reset, asynchronous, active-low
start  in  1  start request; sampled only in IDLE or DONE
cfg_div  in  DIV_W  step period minus 1; latched on accepted start
cfg_sweeps  in  CNT_W  number of LSB arrivals to run; latched on accepted start
pause  in  1  level; freezes pacing while high in RUN
abort  in  1  level; terminates a run
at_lsb  in  1  shifter position bit 0 (Q[0])
shift_ena  out  1  single-cycle step enable to shifter ena
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
sweep_count  out  CNT_W  LSB arrivals counted in current/last run

Behaviour:
- Reset (rstna low, any time, incl. mid-run): state IDLE; shift_ena, busy, done, aborted = 0; sweep_count = 0; prescaler = 0; latched config = 0; pulse_d = 0. Shifter is reset by the same rstna; the controller does not reset the shifter otherwise.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch cfg_div/cfg_sweeps, sweep_count<=0, prescaler<=cfg_div, pulse_d<=0. Next state: RUN if cfg_sweeps!=0. If cfg_sweeps==0, next state is DONE (done pulse next cycle, zero steps).
- start in RUN is ignored. DONE lasts exactly 1 cycle (done=1, busy=0), then IDLE unless start is accepted.
- RUN pacing: shift_ena is combinational: RUN & prescaler==0 & !pause & !abort & !finish.
  - On shift_ena, prescaler reloads cfg_div.
  - Otherwise, when !pause and prescaler!=0, it decrements.
  - pause holds the prescaler.
  - Result: first step in the (D+1)th RUN cycle, then one step every D+1 unpaused cycles. D=0 gives a step every cycle.
- Arrival detect: pulse_d <= shift_ena (registered). arrival = RUN & pulse_d & at_lsb, i.e. the shifter's updated Q is checked the cycle after each step.
  - at_lsb high at start is not counted.
  - Arrivals are counted regardless of pause.
- On arrival: sweep_count += 1. finish = arrival & (sweep_count+1 == latched cfg_sweeps). finish suppresses shift_ena in that same cycle, so the shifter stays at LSB, and state goes to DONE.
- abort=1 in RUN: shift_ena suppressed that cycle, next state IDLE, aborted pulses for 1 cycle. No done is issued. sweep_count holds its last value.
  - abort outranks finish in the same cycle.
  - abort in IDLE/DONE is ignored (no aborted pulse).
- sweep_count never wraps: the run ends at the target, which is at most 2^CNT_W-1.
- After done or aborted, sweep_count holds until the next accepted start.

Test Plan:
- Reset, 8-bit shifter at MSB; start with cfg_div=0, cfg_sweeps=1 -> shift_ena high 7 consecutive cycles, shifter Q=0000_0001, done pulses once, sweep_count=1, busy falls, no 8th pulse.
- start with cfg_div=3, cfg_sweeps=2 from MSB -> shift_ena every 4th cycle, 21 steps total (LSB arrivals after steps 7 and 21), done after step 21, sweep_count=2, Q=0000_0001.
- cfg_sweeps=0 -> no shift_ena, done pulses in the cycle after start, busy never high.
- Mid-run pause held 10 cycles with cfg_div=2 -> no shift_ena and prescaler frozen. After release, the first pulse comes the same remaining count later; total step count unchanged.
- abort asserted on the cycle where the final arrival is detected -> aborted=1, done=0, state IDLE, no further shift_ena.
- rstna dropped mid-run, then released -> all outputs 0, IDLE. start pulses in RUN are ignored (no relatch; pulse spacing unchanged).

Source files
------------

// File: rtl/bounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bounce_scan_ctrl
// Brief    : Paces shift enables for a one-hot bounce shifter, counts LSB
//            arrivals and parks the shifter on the LSB after N sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_scan_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstna,
    input  logic             start,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_sweeps,
    input  logic             pause,
    input  logic             abort,
    input  logic             at_lsb,
    output logic             shift_ena,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] sweep_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_sweeps;
    logic [CNT_W-1:0] r_count;
    logic             r_pulse_d;
    logic             r_aborted;

    logic             w_run;
    logic             w_arrival;
    logic             w_finish;
    logic [CNT_W-1:0] w_count_inc;

    assign w_run       = (r_state == S_RUN);
    assign w_count_inc = r_count + CNT_W'(1);
    // The shifter's Q is only meaningful the cycle after a step we issued.
    assign w_arrival   = w_run & r_pulse_d & at_lsb;
    assign w_finish    = w_arrival & (w_count_inc == r_sweeps);

    assign shift_ena   = w_run & (r_presc == '0) & ~pause & ~abort & ~w_finish;
    assign busy        = w_run;
    assign done        = (r_state == S_DONE);
    assign aborted     = r_aborted;
    assign sweep_count = r_count;

    always_ff @(posedge clk or negedge rstna) begin
        if (!rstna) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_div     <= '0;
            r_sweeps  <= '0;
            r_count   <= '0;
            r_pulse_d <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            r_pulse_d <= shift_ena;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        r_div     <= cfg_div;
                        r_sweeps  <= cfg_sweeps;
                        r_count   <= '0;
                        r_presc   <= cfg_div;
                        r_pulse_d <= 1'b0;
                        r_state   <= (cfg_sweeps != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (shift_ena) begin
                        r_presc <= r_div;
                    end else if (!pause && (r_presc != '0)) begin
                        r_presc <= r_presc - DIV_W'(1);
                    end
                    // Abort outranks a coincident final arrival.
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                    end else if (w_arrival) begin
                        r_count <= w_count_inc;
                        if (w_finish) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_scan_ctrl
// Brief    : Directed table-driven bench for bounce_scan_ctrl with an 8-bit
//            bounce shifter model on its shift_ena output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstna = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [7:0]  cfg_sweeps = '0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic        at_lsb;
    logic        shift_ena;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  sweep_count;

    logic [7:0]  q;
    logic        dir_dn;

    int nchk = 0;
    int nerr = 0;

    int steps, done_cyc, done_n, ab_cyc, ab_n, tail;
    bit busy_seen;
    int tstep[$];

    always #5 clk = ~clk;

    bounce_scan_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
        .clk         (clk),
        .rstna       (rstna),
        .start       (start),
        .cfg_div     (cfg_div),
        .cfg_sweeps  (cfg_sweeps),
        .pause       (pause),
        .abort       (abort),
        .at_lsb      (at_lsb),
        .shift_ena   (shift_ena),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .sweep_count (sweep_count)
    );

    // Shifter model: one-hot bouncing between MSB and LSB, reset at MSB.
    assign at_lsb = q[0];
    always_ff @(posedge clk or negedge rstna) begin
        if (!rstna) begin
            q      <= 8'h80;
            dir_dn <= 1'b1;
        end else if (shift_ena) begin
            if (dir_dn) begin
                q <= q >> 1;
                if (q[1]) dir_dn <= 1'b0;
            end else begin
                q <= q << 1;
                if (q[6]) dir_dn <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstna = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        rstna = 1'b1;
    endtask

    // Cycle k is the k-th cycle after the edge that accepts start.
    task automatic run(input int div, input int sw, input int p_at, input int p_len,
                       input int ab_at, input int rs_at, input int budget);
        steps = 0; done_cyc = -1; done_n = 0; ab_cyc = -1; ab_n = 0;
        busy_seen = 0; tail = -1; tstep.delete();
        @(posedge clk); #1;
        cfg_div = 16'(div); cfg_sweeps = 8'(sw); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_div = 16'd5; cfg_sweeps = 8'd7;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            pause = (k >= p_at) && (k < p_at + p_len);
            abort = (k == ab_at);
            start = (k == rs_at);
            @(negedge clk);
            if (shift_ena) begin steps++; tstep.push_back(k); end
            if (done) begin done_n++; if (done_cyc < 0) done_cyc = k; end
            if (aborted) begin ab_n++; if (ab_cyc < 0) ab_cyc = k; end
            if (busy) busy_seen = 1;
            if (tail < 0 && (done || aborted)) tail = k + 4;
            if (k == tail) break;
        end
        pause = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    typedef struct {
        int div;
        int sw;
        int steps;
        int count;
        int done_cyc;
    } vec_t;

    vec_t vt[5];

    initial begin
        int bad;
        int exp_t[7];

        vt[0] = '{div: 0, sw: 1, steps: 7,  count: 1, done_cyc: 9};
        vt[1] = '{div: 3, sw: 2, steps: 21, count: 2, done_cyc: 86};
        vt[2] = '{div: 0, sw: 0, steps: 0,  count: 0, done_cyc: 1};
        vt[3] = '{div: 1, sw: 3, steps: 35, count: 3, done_cyc: 72};
        vt[4] = '{div: 0, sw: 2, steps: 21, count: 2, done_cyc: 23};

        do_reset();
        @(negedge clk);
        chk("rst_shift_ena", int'(shift_ena), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_sweep_count", int'(sweep_count), 0);
        chk("rst_q", int'(q), 8'h80);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run(vt[i].div, vt[i].sw, 0, 0, 0, 0, 200);
            bad = 0;
            foreach (tstep[j]) if (tstep[j] != (j + 1) * (vt[i].div + 1)) bad++;
            chk($sformatf("v%0d_steps", i), steps, vt[i].steps);
            chk($sformatf("v%0d_spacing_errs", i), bad, 0);
            chk($sformatf("v%0d_sweep_count", i), int'(sweep_count), vt[i].count);
            chk($sformatf("v%0d_done_cycle", i), done_cyc, vt[i].done_cyc);
            chk($sformatf("v%0d_done_pulses", i), done_n, 1);
            chk($sformatf("v%0d_aborted_pulses", i), ab_n, 0);
            chk($sformatf("v%0d_busy_seen", i), int'(busy_seen), (vt[i].sw != 0) ? 1 : 0);
            chk($sformatf("v%0d_q", i), int'(q), (vt[i].sw != 0) ? 8'h01 : 8'h80);
        end

        // Pause cycles 5..14 with div=2: second step slips from cycle 6 to 16.
        do_reset();
        run(2, 1, 5, 10, 0, 0, 200);
        exp_t = '{3, 16, 19, 22, 25, 28, 31};
        bad = 0;
        foreach (tstep[j]) if (j > 6 || tstep[j] != exp_t[j]) bad++;
        chk("pause_steps", steps, 7);
        chk("pause_timing_errs", bad, 0);
        chk("pause_done_cycle", done_cyc, 33);
        chk("pause_sweep_count", int'(sweep_count), 1);

        // start in RUN with different cfg is ignored.
        do_reset();
        run(3, 1, 0, 0, 0, 6, 200);
        bad = 0;
        foreach (tstep[j]) if (tstep[j] != (j + 1) * 4) bad++;
        chk("restart_steps", steps, 7);
        chk("restart_spacing_errs", bad, 0);
        chk("restart_done_cycle", done_cyc, 30);
        chk("restart_sweep_count", int'(sweep_count), 1);

        // Abort on the cycle of the final arrival (cycle 8).
        do_reset();
        run(0, 1, 0, 0, 8, 0, 200);
        chk("abort_steps", steps, 7);
        chk("abort_cycle", ab_cyc, 9);
        chk("abort_pulses", ab_n, 1);
        chk("abort_done_pulses", done_n, 0);
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_q", int'(q), 8'h01);

        // Abort while idle produces no pulse.
        @(posedge clk); #1; abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_pulse", int'(aborted), 0);

        // Asynchronous reset mid-run.
        do_reset();
        @(posedge clk); #1; cfg_div = 16'd0; cfg_sweeps = 8'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("prereset_sweep_count", int'(sweep_count), 1);
        chk("prereset_busy", int'(busy), 1);
        rstna = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_shift_ena", int'(shift_ena), 0);
        chk("midrst_sweep_count", int'(sweep_count), 0);
        chk("midrst_q", int'(q), 8'h80);
        @(posedge clk); #1; rstna = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (shift_ena || busy || done || aborted) bad++;
        end
        chk("postrst_idle_errs", bad, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
